reg_xfer_engine: RTL and testbench
==================================

# reg_xfer_engine

Command-driven register-transfer engine. It owns three 4-bit registers (A, B, C) and a shared 4-bit transfer bus, and executes move, swap, load-immediate and increment commands. Commands arrive over a valid/ready handshake. It replaces the manual switch/button transfer path: a debounced-button front end or a test sequencer issues commands, and its register outputs feed the hex display directly.

## Interface
Parameters:
- none (datapath fixed at 4 bits, 3 registers)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  reset; synchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  engine idle and accepting; forced 0 while rst_n=0
- cmd_op  in  2  00 MOVE, 01 SWAP, 10 LOAD, 11 INC
- cmd_src  in  2  bus source: 0=A, 1=B, 2=C, 3=constant 0
- cmd_dst  in  2  destination: 0=A, 1=B, 2=C, 3=none
- cmd_imm  in  4  immediate for LOAD
- reg_a, reg_b, reg_c  out  4 each  current register contents
- bus  out  4  value driven on the transfer bus this cycle (0 when idle)
- busy  out  1  command in progress (= !cmd_ready outside reset)
- done  out  1  one-cycle pulse: command completed

## Operation
- States: IDLE, EXEC1, EXEC2, EXEC3, FIN.
- Accept when cmd_valid && cmd_ready, in IDLE only. The op, src, dst and imm fields are latched at acceptance. Inputs are ignored at all other times.
- MOVE: IDLE→EXEC1. In EXEC1, bus = reg[src], and dst is written with bus at the end of EXEC1. Then →FIN.
- LOAD: as MOVE, with bus = latched imm.
- INC: as MOVE, with bus = reg[dst] + 1 modulo 16 (F→0 wraps; no carry output).
- SWAP (src/dst ignored): EXEC1 C←A; EXEC2 A←B; EXEC3 B←C (old A). Then →FIN.
- dst=3 (MOVE/LOAD/INC): no register written. The full sequence still runs and done still pulses.
- src=3: bus = 0, so MOVE with src=3 clears dst.
- src==dst is legal: the register rewrites its own value and is unchanged.
- FIN: done=1, cmd_ready=1. A new command may be accepted in FIN (back-to-back); FIN then goes to EXEC1, otherwise to IDLE.
- Only one register is written per cycle. No register changes outside EXEC states.
- Reset (rst_n=0 at an edge):
  - reg_a/reg_b/reg_c = 0, state = IDLE, done = 0, bus = 0.
  - An in-flight command is abandoned. A partial SWAP leaves no residue because all registers clear. No done pulse.

## Timing
- Acceptance edge = T.
- MOVE/LOAD/INC:
  - bus valid during cycle T..T+1.
  - Destination updated at edge T+1.
  - done and cmd_ready high during cycle T+1..T+2, and the new value is visible on reg_* in that same cycle.
  - Latency: 1 cycle.
  - Back-to-back throughput: 1 command per 2 cycles.
- SWAP:
  - Writes at edges T+1 (C), T+2 (A), T+3 (B).
  - done during cycle T+3..T+4.
- cmd_ready is low in EXEC1–EXEC3 and high in IDLE and FIN.
- done is high only in FIN, for exactly one cycle per command.
- bus is combinational from state and registers; 0 in IDLE/FIN.
- cmd_valid held high with no change produces one execution per acceptance. Back-to-back acceptance at FIN re-executes it.

## Test plan
- Reset then idle: rst_n low 2 cycles → reg_a=reg_b=reg_c=0, cmd_ready=0 during reset, then 1. done never pulses.
- LOAD A=5, LOAD B=0xA, MOVE B→C → reg_a=5, reg_b=A, reg_c=A. Each done occurs exactly 1 cycle after its acceptance edge. bus=A during the MOVE EXEC1.
- SWAP with A=3, B=9, C=0:
  - After edge T+1: C=3.
  - After T+2: A=9.
  - After T+3: B=3.
  - done at cycle T+3; cmd_ready low for cycles T..T+2.
- INC wrap on C=F → C=0. INC with dst=3 → no register change, done still pulses. MOVE src=3 → A to A=0.
- Back-to-back: cmd_valid held high across three LOADs → accepted on consecutive FIN cycles, one every 2 cycles, three done pulses.
- Reset mid-SWAP (rst_n low at edge T+2) → all registers 0, state IDLE, no done pulse. A following MOVE executes normally.

Source files
------------

// File: rtl/reg_xfer_engine.sv
// reg_xfer_engine: command-driven transfer engine over three 4-bit registers.
// Executes MOVE, SWAP, LOAD and INC commands accepted over a valid/ready handshake.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous active-low reset
//   cmd_valid  in   command present
//   cmd_ready  out  idle/finishing and accepting (0 in reset)
//   cmd_op     in   00 MOVE, 01 SWAP, 10 LOAD, 11 INC
//   cmd_src    in   bus source A/B/C/zero
//   cmd_dst    in   destination A/B/C/none
//   cmd_imm    in   LOAD immediate
//   reg_a/b/c  out  register contents
//   bus        out  transfer bus value this cycle (0 when idle)
//   busy       out  command in progress
//   done       out  one-cycle completion pulse
module reg_xfer_engine (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [1:0] cmd_src,
  input  logic [1:0] cmd_dst,
  input  logic [3:0] cmd_imm,
  output logic [3:0] reg_a,
  output logic [3:0] reg_b,
  output logic [3:0] reg_c,
  output logic [3:0] bus,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC1,
    S_EXEC2,
    S_EXEC3,
    S_FIN
  } state_e;

  localparam logic [1:0] OP_MOVE = 2'b00;
  localparam logic [1:0] OP_SWAP = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;
  localparam logic [1:0] OP_INC  = 2'b11;

  state_e     state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [1:0] src_q, src_d;
  logic [1:0] dst_q, dst_d;
  logic [3:0] imm_q, imm_d;
  logic [3:0] ra_q, ra_d;
  logic [3:0] rb_q, rb_d;
  logic [3:0] rc_q, rc_d;

  logic [3:0] bus_w;
  logic [3:0] src_val;
  logic [3:0] dst_val;
  logic       ready_w;
  logic       accept;

  // Register read ports; index 3 reads as constant zero.
  always_comb begin
    src_val = 4'h0;
    unique case (src_q)
      2'd0:    src_val = ra_q;
      2'd1:    src_val = rb_q;
      2'd2:    src_val = rc_q;
      default: src_val = 4'h0;
    endcase
  end

  always_comb begin
    dst_val = 4'h0;
    unique case (dst_q)
      2'd0:    dst_val = ra_q;
      2'd1:    dst_val = rb_q;
      2'd2:    dst_val = rc_q;
      default: dst_val = 4'h0;
    endcase
  end

  assign ready_w = (state_q == S_IDLE) || (state_q == S_FIN);
  assign accept  = cmd_valid && rst_n && ready_w;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    src_d   = src_q;
    dst_d   = dst_q;
    imm_d   = imm_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    rc_d    = rc_q;
    bus_w   = 4'h0;

    unique case (state_q)
      S_IDLE, S_FIN: begin
        if (accept) begin
          op_d    = cmd_op;
          src_d   = cmd_src;
          dst_d   = cmd_dst;
          imm_d   = cmd_imm;
          state_d = S_EXEC1;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_EXEC1: begin
        if (op_q == OP_SWAP) begin
          // C takes old A so it survives the A<-B step.
          bus_w   = ra_q;
          rc_d    = bus_w;
          state_d = S_EXEC2;
        end else begin
          unique case (op_q)
            OP_MOVE: bus_w = src_val;
            OP_LOAD: bus_w = imm_q;
            OP_INC:  bus_w = dst_val + 4'h1;
            default: bus_w = 4'h0;
          endcase
          unique case (dst_q)
            2'd0:    ra_d = bus_w;
            2'd1:    rb_d = bus_w;
            2'd2:    rc_d = bus_w;
            default: ;
          endcase
          state_d = S_FIN;
        end
      end

      S_EXEC2: begin
        bus_w   = rb_q;
        ra_d    = bus_w;
        state_d = S_EXEC3;
      end

      S_EXEC3: begin
        bus_w   = rc_q;
        rb_d    = bus_w;
        state_d = S_FIN;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= 2'b00;
      src_q   <= 2'b00;
      dst_q   <= 2'b00;
      imm_q   <= 4'h0;
      ra_q    <= 4'h0;
      rb_q    <= 4'h0;
      rc_q    <= 4'h0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      imm_q   <= imm_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      rc_q    <= rc_d;
    end
  end

  // Handshake and status outputs are held inactive while reset is asserted.
  assign cmd_ready = rst_n && ready_w;
  assign busy      = rst_n && !ready_w;
  assign done      = rst_n && (state_q == S_FIN);
  assign bus       = rst_n ? bus_w : 4'h0;

  assign reg_a = ra_q;
  assign reg_b = rb_q;
  assign reg_c = rc_q;

endmodule

// File: tb/tb_reg_xfer_engine.sv
// Testbench for reg_xfer_engine.
// Scenario tasks with an expected-register scoreboard popped on done.
module tb_reg_xfer_engine;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [1:0] cmd_src;
  logic [1:0] cmd_dst;
  logic [3:0] cmd_imm;
  logic [3:0] reg_a;
  logic [3:0] reg_b;
  logic [3:0] reg_c;
  logic [3:0] bus;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  logic [11:0] sb[$];
  logic [3:0]  ma = 4'h0;
  logic [3:0]  mb = 4'h0;
  logic [3:0]  mc = 4'h0;

  localparam logic [1:0] MOVE = 2'b00;
  localparam logic [1:0] SWAP = 2'b01;
  localparam logic [1:0] LOAD = 2'b10;
  localparam logic [1:0] INC  = 2'b11;

  reg_xfer_engine dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_src   (cmd_src),
    .cmd_dst   (cmd_dst),
    .cmd_imm   (cmd_imm),
    .reg_a     (reg_a),
    .reg_b     (reg_b),
    .reg_c     (reg_c),
    .bus       (bus),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  // Reference model: applies one command to the shadow registers.
  task automatic model(input logic [1:0] op, input logic [1:0] s,
                       input logic [1:0] d, input logic [3:0] imm);
    logic [3:0] v;
    logic [3:0] old_a;
    v = 4'h0;
    if (op == SWAP) begin
      old_a = ma;
      ma = mb;
      mb = old_a;
      mc = old_a;
    end else begin
      case (op)
        MOVE: v = (s == 0) ? ma : (s == 1) ? mb : (s == 2) ? mc : 4'h0;
        LOAD: v = imm;
        default: v = ((d == 0) ? ma : (d == 1) ? mb : (d == 2) ? mc : 4'h0) + 4'h1;
      endcase
      case (d)
        2'd0: ma = v;
        2'd1: mb = v;
        2'd2: mc = v;
        default: ;
      endcase
    end
  endtask

  // Drives a command and returns in the cycle after the acceptance edge.
  task automatic send(input logic [1:0] op, input logic [1:0] s,
                      input logic [1:0] d, input logic [3:0] imm,
                      output bit ok);
    int n;
    n = 0;
    cmd_op = op; cmd_src = s; cmd_dst = d; cmd_imm = imm;
    cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    ok = (n < 20);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 10) begin
      @(posedge clk); #1; cyc++;
    end
  endtask

  // Issues a non-SWAP command and checks latency and final registers.
  task automatic run_cmd(input string nm, input logic [1:0] op,
                         input logic [1:0] s, input logic [1:0] d,
                         input logic [3:0] imm);
    bit ok;
    int cyc;
    logic [11:0] e;
    send(op, s, d, imm, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s accept timeout", nm);
    end
    model(op, s, d, imm);
    sb.push_back({ma, mb, mc});
    wait_done(cyc);
    checks++;
    if (cyc !== 1) begin
      errors++;
      $display("FAIL %s latency got %0d want 1", nm, cyc);
    end
    e = sb.pop_front();
    checks++;
    if ({reg_a, reg_b, reg_c} !== e) begin
      errors++;
      $display("FAIL %s regs got %h want %h", nm, {reg_a, reg_b, reg_c}, e);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = 2'b00; cmd_src = 2'b00; cmd_dst = 2'b00; cmd_imm = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready got %b want 0", cmd_ready);
    end
    checks++;
    if ({reg_a, reg_b, reg_c, bus} !== 16'h0) begin
      errors++;
      $display("FAIL reset_regs got %h want 0", {reg_a, reg_b, reg_c, bus});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({cmd_ready, busy, done} !== 3'b100) begin
      errors++;
      $display("FAIL idle_status got %b want 100", {cmd_ready, busy, done});
    end
    checks++;
    if (done_cnt !== 0) begin
      errors++;
      $display("FAIL reset_done got %0d want 0", done_cnt);
    end
  endtask

  task automatic test_load_move;
    bit ok;
    int cyc;
    logic [11:0] e;
    run_cmd("load_a", LOAD, 2'd0, 2'd0, 4'h5);
    run_cmd("load_b", LOAD, 2'd0, 2'd1, 4'hA);
    send(MOVE, 2'd1, 2'd2, 4'h0, ok);
    checks++;
    if (bus !== 4'hA || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL move_bus got %h/%b want a/0", bus, cmd_ready);
    end
    model(MOVE, 2'd1, 2'd2, 4'h0);
    sb.push_back({ma, mb, mc});
    wait_done(cyc);
    checks++;
    if (cyc !== 1) begin
      errors++;
      $display("FAIL move_latency got %0d want 1", cyc);
    end
    e = sb.pop_front();
    checks++;
    if ({reg_a, reg_b, reg_c} !== e) begin
      errors++;
      $display("FAIL move_regs got %h want %h", {reg_a, reg_b, reg_c}, e);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_swap;
    bit ok;
    logic [11:0] e;
    run_cmd("pre_a", LOAD, 2'd0, 2'd0, 4'h3);
    run_cmd("pre_b", LOAD, 2'd0, 2'd1, 4'h9);
    run_cmd("pre_c", MOVE, 2'd3, 2'd2, 4'h0);
    send(SWAP, 2'd0, 2'd0, 4'h0, ok);
    model(SWAP, 2'd0, 2'd0, 4'h0);
    sb.push_back({ma, mb, mc});
    checks++;
    if ({cmd_ready, bus} !== 5'h03) begin
      errors++;
      $display("FAIL swap_t0 got %h want 03", {cmd_ready, bus});
    end
    @(posedge clk); #1;
    checks++;
    if ({reg_a, reg_b, reg_c, cmd_ready} !== {12'h393, 1'b0}) begin
      errors++;
      $display("FAIL swap_t1 got %h want %h", {reg_a, reg_b, reg_c, cmd_ready}, {12'h393, 1'b0});
    end
    @(posedge clk); #1;
    checks++;
    if ({reg_a, reg_b, reg_c, cmd_ready} !== {12'h993, 1'b0}) begin
      errors++;
      $display("FAIL swap_t2 got %h want %h", {reg_a, reg_b, reg_c, cmd_ready}, {12'h993, 1'b0});
    end
    @(posedge clk); #1;
    checks++;
    if ({done, cmd_ready} !== 2'b11) begin
      errors++;
      $display("FAIL swap_done got %b want 11", {done, cmd_ready});
    end
    e = sb.pop_front();
    checks++;
    if ({reg_a, reg_b, reg_c} !== e) begin
      errors++;
      $display("FAIL swap_regs got %h want %h", {reg_a, reg_b, reg_c}, e);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_inc;
    run_cmd("load_cf", LOAD, 2'd0, 2'd2, 4'hF);
    run_cmd("inc_wrap", INC, 2'd0, 2'd2, 4'h0);
    run_cmd("inc_none", INC, 2'd0, 2'd3, 4'h0);
    run_cmd("inc_b", INC, 2'd0, 2'd1, 4'h0);
    run_cmd("move_self", MOVE, 2'd1, 2'd1, 4'h0);
    run_cmd("clr_a", MOVE, 2'd3, 2'd0, 4'h0);
  endtask

  task automatic test_back_to_back;
    int n;
    int d0;
    logic [11:0] e;
    logic [1:0] dl[3];
    logic [3:0] im[3];
    dl[0] = 2'd0; dl[1] = 2'd1; dl[2] = 2'd2;
    im[0] = 4'h7; im[1] = 4'hC; im[2] = 4'h2;
    d0 = done_cnt;
    n = 0;
    cmd_op = LOAD; cmd_src = 2'd0; cmd_dst = dl[0]; cmd_imm = im[0];
    cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      model(LOAD, 2'd0, dl[k], im[k]);
      sb.push_back({ma, mb, mc});
      checks++;
      if ({done, cmd_ready} !== 2'b00) begin
        errors++;
        $display("FAIL b2b_exec%0d got %b want 00", k, {done, cmd_ready});
      end
      if (k < 2) begin
        cmd_dst = dl[k+1];
        cmd_imm = im[k+1];
      end
      @(posedge clk); #1;
      checks++;
      if ({done, cmd_ready} !== 2'b11) begin
        errors++;
        $display("FAIL b2b_fin%0d got %b want 11", k, {done, cmd_ready});
      end
      e = sb.pop_front();
      checks++;
      if ({reg_a, reg_b, reg_c} !== e) begin
        errors++;
        $display("FAIL b2b_regs%0d got %h want %h", k, {reg_a, reg_b, reg_c}, e);
      end
      if (k == 2) cmd_valid = 1'b0;
      @(posedge clk); #1;
    end
    checks++;
    if ({done, cmd_ready, done_cnt - d0} !== {2'b01, 32'd3}) begin
      errors++;
      $display("FAIL b2b_end got %b/%0d want 01/3", {done, cmd_ready}, done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid_swap;
    bit ok;
    int d0;
    d0 = done_cnt;
    send(SWAP, 2'd0, 2'd0, 4'h0, ok);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({reg_a, reg_b, reg_c, bus, cmd_ready, done} !== 18'h0) begin
      errors++;
      $display("FAIL midswap_rst got %h want 0", {reg_a, reg_b, reg_c, bus, cmd_ready, done});
    end
    rst_n = 1'b1;
    ma = 4'h0; mb = 4'h0; mc = 4'h0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if ({done_cnt - d0, busy, cmd_ready} !== {32'd0, 2'b01}) begin
      errors++;
      $display("FAIL midswap_idle got %0d/%b want 0/01", done_cnt - d0, {busy, cmd_ready});
    end
    run_cmd("post_load", LOAD, 2'd0, 2'd0, 4'h6);
    run_cmd("post_move", MOVE, 2'd0, 2'd1, 4'h0);
  endtask

  initial begin
    test_reset();
    test_load_move();
    test_swap();
    test_inc();
    test_back_to_back();
    test_reset_mid_swap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
